// File: rtl/self_purging_voter.sv
// ---------------------------------------------------------------------------
// self_purging_voter
//   Bitwise majority voter for N redundant adder replicas. Each replica's
//   vote word is {carry, sum}. Replicas that disagree with the voted word
//   for PURGE_THR votes in a row are purged and no longer take part.
//   Pipeline: stage 1 registers the replica outputs. Stage 2 votes and
//   registers the result. Latency is 2 cycles and one vote can be issued
//   per cycle.
//
// Parameters
//   WIDTH     : bit width of each replica sum
//   N         : number of replicas (3..7)
//   PURGE_THR : consecutive mismatching votes that purge a replica (1..3)
//
// Ports
//   clk          in   clock; all state updates on the rising edge
//   rst_n        in   synchronous active-low reset (has priority over J)
//   J            in   synchronous purge-init: re-enables every replica and
//                     drops any in-flight result
//   in_valid     in   replica outputs are valid this cycle
//   mod_sum      in   packed replica sums; replica i is [i*WIDTH +: WIDTH]
//   mod_cout     in   replica carry-outs; bit i belongs to replica i
//   out_valid    out  voted result valid
//   out_sum      out  voted sum
//   out_cout     out  voted carry-out
//   mod_en       out  per-replica enable; 0 means the replica is purged
//   tie_err      out  at least one bit of this result was an even split
//   all_fail     out  sticky: fewer than 2 replicas remain enabled
//   mismatch_cnt out  number of results where an enabled replica disagreed
//
// Build option
//   SPV_STATS_EN : when defined, mismatch_cnt is a saturating 16-bit event
//                  counter cleared only by reset. When undefined it is tied
//                  to 0.
// ---------------------------------------------------------------------------
module self_purging_voter #(
  parameter int WIDTH     = 32,
  parameter int N         = 5,
  parameter int PURGE_THR = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 J,
  input  logic                 in_valid,
  input  logic [N*WIDTH-1:0]   mod_sum,
  input  logic [N-1:0]         mod_cout,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_sum,
  output logic                 out_cout,
  output logic [N-1:0]         mod_en,
  output logic                 tie_err,
  output logic                 all_fail,
  output logic [15:0]          mismatch_cnt
);

  localparam int VW = WIDTH + 1;

  function automatic int popcnt(input logic [N-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

  function automatic logic [1:0] sat_inc2(input logic [1:0] s);
    return (s == 2'b11) ? s : s + 2'd1;
  endfunction

  logic                   vld_p1;
  logic [N*WIDTH-1:0]     sum_p1;
  logic [N-1:0]           cout_p1;

  logic [N-1:0][VW-1:0]   word_p1;
  logic [VW-1:0]          voted;
  logic                   tie;
  logic [N-1:0]           mism;
  logic                   pair_split;
  int                     en_cnt;
  logic [N-1:0][1:0]      strike;
  logic [N-1:0][1:0]      strike_nx;
  logic [N-1:0]           en_nx;

  // ---- stage 1: capture replica outputs --------------------------------
  always_ff @(posedge clk) begin
    if (in_valid && !J) begin
      sum_p1  <= mod_sum;
      cout_p1 <= mod_cout;
    end
  end

  // ---- stage 2: vote, compare, strike bookkeeping ----------------------
  always_comb begin
    int ones;
    for (int i = 0; i < N; i++) begin
      word_p1[i] = {cout_p1[i], sum_p1[i*WIDTH +: WIDTH]};
    end
    en_cnt = popcnt(mod_en);

    // A bit is 1 only with a strict majority of enabled replicas. An even
    // split votes 0 and flags the result as undecidable.
    voted = '0;
    tie   = 1'b0;
    for (int b = 0; b < VW; b++) begin
      ones = 0;
      for (int i = 0; i < N; i++) begin
        if (mod_en[i] && word_p1[i][b]) ones++;
      end
      if (2 * ones > en_cnt) voted[b] = 1'b1;
      if (en_cnt >= 2 && 2 * ones == en_cnt) tie = 1'b1;
    end

    for (int i = 0; i < N; i++) begin
      mism[i] = mod_en[i] && (word_p1[i] != voted);
    end

    // With only two replicas left, a disagreement cannot identify the
    // faulty one, so nobody is struck.
    pair_split = (en_cnt == 2) && (|mism);

    strike_nx = strike;
    en_nx     = mod_en;
    if (vld_p1 && !pair_split) begin
      for (int i = 0; i < N; i++) begin
        if (mod_en[i]) begin
          if (mism[i]) begin
            strike_nx[i] = sat_inc2(strike[i]);
            if (int'(strike_nx[i]) >= PURGE_THR) en_nx[i] = 1'b0;
          end else begin
            strike_nx[i] = 2'b00;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      tie_err   <= 1'b0;
      all_fail  <= 1'b0;
      mod_en    <= '1;
      strike    <= '0;
    end else if (J) begin
      // J wins over any purge on the same edge and drops both valid flags.
      vld_p1    <= 1'b0;
      out_valid <= 1'b0;
      all_fail  <= 1'b0;
      mod_en    <= '1;
      strike    <= '0;
    end else begin
      vld_p1    <= in_valid;
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_sum  <= voted[WIDTH-1:0];
        out_cout <= voted[WIDTH];
        tie_err  <= tie;
        mod_en   <= en_nx;
        strike   <= strike_nx;
        if (popcnt(en_nx) < 2) all_fail <= 1'b1;
      end
    end
  end

`ifdef SPV_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic [15:0] mcnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcnt <= '0;
    end else if (!J && vld_p1 && (|mism)) begin
      mcnt <= sat_inc16(mcnt);
    end
  end

  assign mismatch_cnt = mcnt;
`else
  assign mismatch_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_self_purging_voter.sv
module tb_self_purging_voter;

  localparam int W   = 32;
  localparam int NR  = 5;
  localparam int THR = 2;

  logic              clk = 1'b0;
  logic              rst_n, J, in_valid;
  logic [NR*W-1:0]   mod_sum;
  logic [NR-1:0]     mod_cout;
  logic              out_valid, out_cout, tie_err, all_fail;
  logic [W-1:0]      out_sum;
  logic [NR-1:0]     mod_en;
  logic [15:0]       mismatch_cnt;

  int errors = 0;
  int checks = 0;

  self_purging_voter #(.WIDTH(W), .N(NR), .PURGE_THR(THR)) dut (
    .clk(clk), .rst_n(rst_n), .J(J), .in_valid(in_valid),
    .mod_sum(mod_sum), .mod_cout(mod_cout),
    .out_valid(out_valid), .out_sum(out_sum), .out_cout(out_cout),
    .mod_en(mod_en), .tie_err(tie_err), .all_fail(all_fail),
    .mismatch_cnt(mismatch_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state: a cycle-level description of the voter.
  logic          m_v1;
  logic [W:0]    m_w [NR];
  logic          m_ov, m_cout, m_tie, m_af;
  logic [W-1:0]  m_sum;
  logic [NR-1:0] m_en;
  int            m_st [NR];
  int            m_mc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int cnt_en(input logic [NR-1:0] e);
    int c = 0;
    for (int i = 0; i < NR; i++) if (e[i]) c++;
    return c;
  endfunction

  task automatic model_vote();
    int e, ones, a, b;
    logic [W:0] v;
    logic tie, any, split;
    e = cnt_en(m_en);
    v = '0; tie = 1'b0;
    for (int bit_i = 0; bit_i <= W; bit_i++) begin
      ones = 0;
      for (int i = 0; i < NR; i++) if (m_en[i] && m_w[i][bit_i]) ones++;
      if (2 * ones > e) v[bit_i] = 1'b1;
      if (e >= 2 && 2 * ones == e) tie = 1'b1;
    end
    any = 1'b0;
    for (int i = 0; i < NR; i++) if (m_en[i] && m_w[i] != v) any = 1'b1;
    a = -1; b = -1;
    for (int i = 0; i < NR; i++) if (m_en[i]) begin
      if (a < 0) a = i; else b = i;
    end
    split = (e == 2) && (m_w[a] != m_w[b]);
    if (!split) begin
      for (int i = 0; i < NR; i++) if (m_en[i]) begin
        if (m_w[i] != v) begin
          m_st[i] = (m_st[i] < 3) ? m_st[i] + 1 : 3;
          if (m_st[i] >= THR) m_en[i] = 1'b0;
        end else begin
          m_st[i] = 0;
        end
      end
    end
    if (cnt_en(m_en) < 2) m_af = 1'b1;
    if (any && m_mc < 65535) m_mc++;
    m_sum = v[W-1:0];
    m_cout = v[W];
    m_tie = tie;
  endtask

  task automatic model_clock();
    if (!rst_n) begin
      m_v1 = 0; m_ov = 0; m_sum = '0; m_cout = 0; m_tie = 0; m_af = 0;
      m_en = '1; m_mc = 0;
      for (int i = 0; i < NR; i++) m_st[i] = 0;
    end else if (J) begin
      m_v1 = 0; m_ov = 0; m_af = 0; m_en = '1;
      for (int i = 0; i < NR; i++) m_st[i] = 0;
    end else begin
      m_ov = m_v1;
      if (m_v1) model_vote();
      m_v1 = in_valid;
      if (in_valid)
        for (int i = 0; i < NR; i++) m_w[i] = {mod_cout[i], mod_sum[i*W +: W]};
    end
  endtask

  // One clock: update model on the edge, compare #1 later, return at negedge.
  task automatic cycle();
    logic [15:0] exp_mc;
    @(posedge clk);
    model_clock();
    #1;
`ifdef SPV_STATS_EN
    exp_mc = 16'(m_mc);
`else
    exp_mc = 16'd0;
`endif
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("out_sum", 64'(out_sum), 64'(m_sum));
    chk("out_cout", 64'(out_cout), 64'(m_cout));
    chk("tie_err", 64'(tie_err), 64'(m_tie));
    chk("mod_en", 64'(mod_en), 64'(m_en));
    chk("all_fail", 64'(all_fail), 64'(m_af));
    chk("mismatch_cnt", 64'(mismatch_cnt), 64'(exp_mc));
    @(negedge clk);
  endtask

  task automatic vote(input logic [W-1:0] v0, v1, v2, v3, v4, input logic [NR-1:0] c);
    mod_sum = {v4, v3, v2, v1, v0};
    mod_cout = c;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic purge(input int r);
    logic [W-1:0] v [NR];
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < NR; i++) v[i] = (i == r) ? 32'd99 : 32'd42;
      vote(v[0], v[1], v[2], v[3], v[4], 5'b00000);
    end
    idle(2);
  endtask

  initial begin
    logic [W-1:0] base, vv [NR];
    logic [NR-1:0] cc;
    logic          cb;
    rst_n = 1'b0; J = 1'b0; in_valid = 1'b0; mod_sum = '0; mod_cout = '0;
    cycle(); cycle();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_mod_en", 64'(mod_en), 64'h1F);
    chk("reset_mismatch_cnt", 64'(mismatch_cnt), 64'd0);
    rst_n = 1'b1;
    idle(1);

    // Agreement: 4+6 on every replica
    vote(10, 10, 10, 10, 10, 5'b00000);
    chk("agree_latency_1", 64'(out_valid), 64'd0);
    idle(1);
    chk("agree_out_valid", 64'(out_valid), 64'd1);
    chk("agree_out_sum", 64'(out_sum), 64'd10);
    chk("agree_tie", 64'(tie_err), 64'd0);
    idle(1);

    // Single fault on replica 2, two back-to-back votes
    vote(5, 5, 7, 5, 5, 5'b00000);
    vote(5, 5, 7, 5, 5, 5'b00000);
    idle(1);
    chk("fault_sum_1", 64'(out_sum), 64'd5);
    idle(1);
    chk("fault_sum_2", 64'(out_sum), 64'd5);
    chk("fault_mod_en", 64'(mod_en), 64'h1B);
`ifdef SPV_STATS_EN
    chk("fault_mismatch_cnt", 64'(mismatch_cnt), 64'd2);
`endif
    J = 1'b1; cycle(); J = 1'b0;
    chk("j_restore_en", 64'(mod_en), 64'h1F);

    // Transient fault on replica 0
    vote(8, 9, 9, 9, 9, 5'b00000);
    vote(9, 9, 9, 9, 9, 5'b00000);
    idle(2);
    chk("transient_mod_en", 64'(mod_en), 64'h1F);

    // Degradation to two replicas that disagree by one bit
    purge(0); purge(1); purge(2);
    chk("degrade_mod_en", 64'(mod_en), 64'h18);
    vote(0, 0, 0, 30, 31, 5'b00000);
    vote(0, 0, 0, 30, 31, 5'b00000);
    idle(2);
    chk("pair_tie", 64'(tie_err), 64'd1);
    chk("pair_sum", 64'(out_sum), 64'd30);
    chk("pair_no_purge", 64'(mod_en), 64'h18);
    chk("pair_all_fail", 64'(all_fail), 64'd0);
    J = 1'b1; cycle(); J = 1'b0;

    // Two replicas struck together leaves a single survivor
    purge(0); purge(1);
    vote(0, 0, 3, 5, 1, 5'b00000);
    vote(0, 0, 3, 5, 1, 5'b00000);
    idle(2);
    chk("single_mod_en", 64'(mod_en), 64'h10);
    chk("single_all_fail", 64'(all_fail), 64'd1);
    vote(1, 2, 3, 4, 77, 5'b10000);
    idle(1);
    chk("single_follow_sum", 64'(out_sum), 64'd77);
    chk("single_follow_cout", 64'(out_cout), 64'd1);

    // Recovery: J with coincident in_valid drops the input
    J = 1'b1;
    vote(1, 1, 1, 1, 1, 5'b00000);
    J = 1'b0;
    chk("recover_mod_en", 64'(mod_en), 64'h1F);
    chk("recover_all_fail", 64'(all_fail), 64'd0);
    idle(2);
    chk("recover_dropped", 64'(out_valid), 64'd0);
    vote(48, 48, 48, 48, 48, 5'b00000);
    idle(1);
    chk("recover_sum", 64'(out_sum), 64'd48);

    // All replicas purged: output forced to zero but still valid
    purge(0); purge(1);
    vote(0, 0, 1, 2, 4, 5'b00000);
    vote(0, 0, 1, 2, 4, 5'b00000);
    idle(2);
    chk("none_mod_en", 64'(mod_en), 64'h00);
    vote(123, 123, 123, 123, 123, 5'b11111);
    idle(1);
    chk("none_valid", 64'(out_valid), 64'd1);
    chk("none_sum", 64'(out_sum), 64'd0);
    chk("none_cout", 64'(out_cout), 64'd0);
    J = 1'b1; cycle(); J = 1'b0;

    // Randomized traffic with occasional faults and J pulses
    for (int k = 0; k < 150; k++) begin
      base = $urandom;
      cb = 1'($urandom_range(0, 1));
      for (int i = 0; i < NR; i++) begin
        vv[i] = base;
        cc[i] = cb;
        if ($urandom_range(0, 5) == 0) vv[i] = base ^ (32'd1 << $urandom_range(0, 31));
        if ($urandom_range(0, 9) == 0) cc[i] = ~cb;
      end
      mod_sum = {vv[4], vv[3], vv[2], vv[1], vv[0]};
      mod_cout = cc;
      in_valid = ($urandom_range(0, 3) != 0);
      J = ($urandom_range(0, 24) == 0) || (cnt_en(m_en) < 3 && $urandom_range(0, 3) == 0);
      cycle();
    end
    J = 1'b0; in_valid = 1'b0;
    idle(2);

    // Reset one cycle after in_valid, with J asserted too
    vote(5, 5, 7, 5, 5, 5'b00000);
    rst_n = 1'b0; J = 1'b1;
    cycle();
    rst_n = 1'b1; J = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_mod_en", 64'(mod_en), 64'h1F);
    idle(2);
    chk("rst_no_late_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
